// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared types for the EX/MEM pipeline stage of the mini-MIPS core:
//   - ex_mem_payload_t : everything the memory stage needs from one instruction
//   - FLAG_* indices   : bit positions inside the sticky FP flag vector
//   - skid_state_e     : occupancy of the two-entry skid buffer
package ex_mem_stage_pkg;

  localparam int EXM_DATA_W     = 32;
  localparam int EXM_REG_ADDR_W = 5;

  // Bit positions in fp_flags_q = {invalid, overflow, underflow}
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  typedef struct packed {
    logic [EXM_DATA_W-1:0]     result;
    logic                      zero;
    logic [EXM_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic [EXM_DATA_W-1:0]     store_data;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // nothing buffered
    S_ONE   = 2'd1,  // main entry only
    S_FULL  = 2'd2   // main + skid entry
  } skid_state_e;

endpackage

// File: rtl/ex_mem_stage_skid_buffer2.sv
// skid_buffer2
// Two-entry valid/ready skid buffer with a registered in_ready. The main
// entry is always the head presented downstream; the skid entry only
// catches the one extra beat accepted while the head is stalled.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop every buffered entry (and any entry offered now)
//   in_valid/in_ready   upstream handshake (in_ready is a flop)
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake
//   out_data            head payload, stable while stalled
module skid_buffer2
  import ex_mem_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;
  logic         accept, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          skid_d  = in_data;
          state_d = S_FULL;
        end else if (accept && pop) begin
          main_d  = in_data;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only a pop can move things
        if (pop) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush only kills occupancy; stale payload bits are harmless
    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Registered ready: look ahead at the next occupancy
      in_ready_q <= (state_d != S_FULL);
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register of the mini-MIPS core. Buffers ALU results plus
// control/writeback info through a two-entry skid buffer, keeps the
// architectural FP condition code and sticky FP exception flags, and taps
// the head entry for register forwarding.
// Ports:
//   clk, rst_n, flush     clock, sync active-low reset, pipeline flush
//   in_*                  execute-stage entry + handshake (in_ready registered)
//   out_*                 head entry + handshake to the memory stage
//   fp_cc_q               FP condition code (bc1t/bc1f)
//   fp_flags_q, flag_clr  sticky {invalid, overflow, underflow} and its clear
//   fwd_*                 forwarding tap of the head entry
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = EXM_DATA_W,
  parameter int REG_ADDR_W = EXM_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_zero,
  input  logic                  in_fp_cc,
  input  logic                  in_invalid,
  input  logic                  in_overflow,
  input  logic                  in_underflow,
  input  logic                  in_is_float,
  input  logic                  in_cc_write,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [DATA_W-1:0]     in_store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic                  out_zero,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [DATA_W-1:0]     out_store_data,
  output logic                  fp_cc_q,
  output logic [2:0]            fp_flags_q,
  input  logic                  flag_clr,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
);

  localparam int PW = $bits(ex_mem_payload_t);

  ex_mem_payload_t in_pl, out_pl;
  logic            accept;
  logic            fp_cc_d;
  logic [2:0]      fp_flags_d, new_flags;

  always_comb begin
    in_pl            = '0;
    in_pl.result     = in_result;
    in_pl.zero       = in_zero;
    in_pl.rd         = in_rd;
    in_pl.reg_write  = in_reg_write;
    in_pl.mem_read   = in_mem_read;
    in_pl.mem_write  = in_mem_write;
    in_pl.store_data = in_store_data;
  end

  skid_buffer2 #(.W(PW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign out_result     = out_pl.result;
  assign out_zero       = out_pl.zero;
  assign out_rd         = out_pl.rd;
  assign out_reg_write  = out_pl.reg_write;
  assign out_mem_read   = out_pl.mem_read;
  assign out_mem_write  = out_pl.mem_write;
  assign out_store_data = out_pl.store_data;

  // r0 is hardwired to zero, so writes to it must never be forwarded
  assign fwd_valid = out_valid & out_pl.reg_write & (out_pl.rd != '0);
  assign fwd_rd    = out_pl.rd;
  assign fwd_data  = out_pl.result;

  assign accept = in_valid & in_ready;

  always_comb begin
    new_flags           = '0;
    new_flags[FLAG_INV] = in_invalid;
    new_flags[FLAG_OVF] = in_overflow;
    new_flags[FLAG_UNF] = in_underflow;

    fp_cc_d    = fp_cc_q;
    fp_flags_d = fp_flags_q;
    if (accept && !flush && in_cc_write) fp_cc_d = in_fp_cc;
    // Clear before set: a ctc1 in the same cycle as a flagging op keeps the new flags
    if (flag_clr) fp_flags_d = '0;
    if (accept && !flush && in_is_float) fp_flags_d = fp_flags_d | new_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fp_cc_q    <= 1'b0;
      fp_flags_q <= '0;
    end else begin
      fp_cc_q    <= fp_cc_d;
      fp_flags_q <= fp_flags_d;
    end
  end

endmodule
